// File: rtl/lfsr4_checker_if.sv
// Sample/status bundle between an upstream 4-bit XNOR LFSR source and lfsr4_checker.
// The master drives samples and observes status; the slave is the checker.
interface lfsr4_checker_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [3:0] expected;

    modport master (
        output in_valid, in_data,
        input  locked, err_pulse, err_count, expected
    );

    modport slave (
        input  in_valid, in_data,
        output locked, err_pulse, err_count, expected
    );
endinterface

// File: rtl/lfsr4_checker.sv
// Acquires and tracks a 4-bit XNOR LFSR stream (HUNT -> SYNC -> LOCK), flags mismatches in LOCK.
// Optional saturating error counter is built only when LFSR4_CHECKER_ERRCNT_EN is defined.
//
// state | meaning
// HUNT  | waiting for a usable seed word (1111 is the XNOR lock-up word, ignored)
// SYNC  | counting consecutive predicted matches toward LOCK_THRESH
// LOCK  | flywheel prediction; LOSS_THRESH consecutive mismatches drop back to HUNT
module lfsr4_checker #(
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr4_checker_if.slave       bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_THRESH - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);

    state_t     r_state;
    logic [3:0] r_expected;
    logic [3:0] r_match_cnt;
    logic [3:0] r_loss_cnt;
    logic       r_locked;
    logic       r_err_pulse;

    logic [3:0] w_next_in;
    logic [3:0] w_next_exp;
    logic       w_mismatch;
    logic       w_lockup;

    assign w_next_in  = {bus.in_data[2:0], ~(bus.in_data[2] ^ bus.in_data[3])};
    assign w_next_exp = {r_expected[2:0], ~(r_expected[2] ^ r_expected[3])};
    assign w_mismatch = (bus.in_data != r_expected);
    assign w_lockup   = (bus.in_data == 4'b1111);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_expected  <= 4'b0000;
            r_match_cnt <= 4'd0;
            r_loss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (!w_lockup) begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= 4'd0;
                            r_state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (!w_mismatch) begin
                            r_expected <= w_next_exp;
                            if (r_match_cnt == LOCK_LAST) begin
                                r_state     <= LOCK;
                                r_locked    <= 1'b1;
                                r_match_cnt <= 4'd0;
                                r_loss_cnt  <= 4'd0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 4'd1;
                            end
                        end else if (w_lockup) begin
                            // a mismatching lock-up word is a rejected seed: back to HUNT
                            r_state     <= HUNT;
                            r_match_cnt <= 4'd0;
                        end else begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= 4'd0;
                        end
                    end
                    LOCK: begin
                        r_expected <= w_next_exp;
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            if (r_loss_cnt == LOSS_LAST) begin
                                r_state    <= HUNT;
                                r_locked   <= 1'b0;
                                r_loss_cnt <= 4'd0;
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 4'd1;
                            end
                        end else begin
                            r_loss_cnt <= 4'd0;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.expected  = r_expected;

`ifdef LFSR4_CHECKER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'h00;
        end else if (bus.in_valid && (r_state == LOCK) && w_mismatch && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_lfsr4_checker.sv
// Scoreboard bench for lfsr4_checker: directed samples push expected status, a monitor
// pops and compares after every clock edge that consumed a driven cycle.
module tb_lfsr4_checker;

    typedef struct {
        logic       l;
        logic       p;
        logic [7:0] c;
        logic [3:0] x;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ecnt;
    exp_t sb[$];

    lfsr4_checker_if bus ();

    lfsr4_checker #(
        .LOCK_THRESH(4),
        .LOSS_THRESH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ec(input int n);
`ifdef LFSR4_CHECKER_ERRCNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // drive one cycle; n = cumulative LOCK error count after this edge
    task automatic drv(input logic v, input logic [3:0] d, input logic l, input logic p,
                       input int n, input logic [3:0] x);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        e.l = l; e.p = p; e.c = ec(n); e.x = x;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            #1;
            chk("locked",    8'(bus.locked),    8'(e.l));
            chk("err_pulse", 8'(bus.err_pulse), 8'(e.p));
            chk("err_count", bus.err_count,     e.c);
            chk("expected",  8'(bus.expected),  8'(e.x));
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_locked"},    8'(bus.locked),    8'h00);
        chk({tag, "_err_pulse"}, 8'(bus.err_pulse), 8'h00);
        chk({tag, "_err_count"}, bus.err_count,     8'h00);
        chk({tag, "_expected"},  8'(bus.expected),  8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 4'b0000;
        rst = 1'b0;
        #1;
        chk_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        ecnt   = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'b0000;
        #2 rst = 1'b0;

        do_reset();

        // acquisition and lock
        drv(1, 4'b0000, 0, 0, 0, 4'b0001);
        drv(1, 4'b0001, 0, 0, 0, 4'b0011);
        drv(1, 4'b0011, 0, 0, 0, 4'b0111);
        drv(1, 4'b0111, 0, 0, 0, 4'b1110);
        drv(1, 4'b1110, 1, 0, 0, 4'b1101);
        // single corrupted word, flywheel continues
        drv(1, 4'b1101, 1, 0, 0, 4'b1011);
        drv(1, 4'b0000, 1, 1, 1, 4'b0110);
        drv(0, 4'b0110, 1, 0, 1, 4'b0110);
        drv(1, 4'b0110, 1, 0, 1, 4'b1100);
        drv(1, 4'b1100, 1, 0, 1, 4'b1001);
        drv(0, 4'b0000, 1, 0, 1, 4'b1001);
        // three consecutive errors -> loss of lock
        drv(1, 4'b0000, 1, 1, 2, 4'b0010);
        drv(1, 4'b0000, 1, 1, 3, 4'b0101);
        drv(1, 4'b0000, 0, 1, 4, 4'b1010);
        drv(1, 4'b0101, 0, 0, 4, 4'b1010);
        // SYNC mismatch reseeds; SYNC lock-up word returns to HUNT
        drv(1, 4'b0011, 0, 0, 4, 4'b0111);
        drv(1, 4'b1111, 0, 0, 4, 4'b0111);
        drv(1, 4'b1111, 0, 0, 4, 4'b0111);
        drv(1, 4'b1001, 0, 0, 4, 4'b0010);

        do_reset();

        // HUNT ignores lock-up word; lock with idle gaps between samples
        drv(1, 4'b1111, 0, 0, 0, 4'b0000);
        drv(1, 4'b1111, 0, 0, 0, 4'b0000);
        drv(1, 4'b1001, 0, 0, 0, 4'b0010);
        drv(1, 4'b0010, 0, 0, 0, 4'b0101);
        drv(0, 4'b1111, 0, 0, 0, 4'b0101);
        drv(1, 4'b0101, 0, 0, 0, 4'b1010);
        drv(0, 4'b0000, 0, 0, 0, 4'b1010);
        drv(1, 4'b1010, 0, 0, 0, 4'b0100);
        drv(0, 4'b1010, 0, 0, 0, 4'b0100);
        drv(1, 4'b0100, 1, 0, 0, 4'b1000);
        drv(1, 4'b1000, 1, 0, 0, 4'b0000);
        drv(1, 4'b0000, 1, 0, 0, 4'b0001);
        // a match between errors clears the loss counter
        drv(1, 4'b1111, 1, 1, 1, 4'b0011);
        drv(1, 4'b0011, 1, 0, 1, 4'b0111);
        drv(1, 4'b0000, 1, 1, 2, 4'b1110);
        drv(1, 4'b0000, 1, 1, 3, 4'b1101);

        // asynchronous reset between edges while locked
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk);
        rst = 1'b1;
        ecnt = 0;

        // repeated lock/loss rounds drive the error counter into saturation
        for (int r = 0; r < 86; r++) begin
            drv(1, 4'b0000, 0, 0, ecnt, 4'b0001);
            drv(1, 4'b0001, 0, 0, ecnt, 4'b0011);
            drv(1, 4'b0011, 0, 0, ecnt, 4'b0111);
            drv(1, 4'b0111, 0, 0, ecnt, 4'b1110);
            drv(1, 4'b1110, 1, 0, ecnt, 4'b1101);
            ecnt++;
            drv(1, 4'b0000, 1, 1, ecnt, 4'b1011);
            ecnt++;
            drv(1, 4'b0000, 1, 1, ecnt, 4'b0110);
            ecnt++;
            drv(1, 4'b0000, 0, 1, ecnt, 4'b1100);
        end
        drv(0, 4'b0000, 0, 0, ecnt, 4'b1100);

        begin
            int waited;
            waited = 0;
            while (sb.size() > 0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            @(negedge clk);
            if (sb.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
